// File: rtl/pixel_timing_pkg.sv
// Shared types and default 640x480@60 timing for the raster timing generator.
package pixel_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } axis_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int CNT_W_DEF    = 10;

    function automatic int total_len(input int a, input int f, input int s, input int b);
        return a + f + s + b;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
// state_next exposes the phase that will hold after this edge so the parent can register outputs with zero latency.
module timing_axis
    import pixel_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = H_ACTIVE_DEF,
    parameter int FRONT_LEN  = H_FRONT_DEF,
    parameter int SYNC_LEN   = H_SYNC_DEF,
    parameter int BACK_LEN   = H_BACK_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output axis_state_t      state_next,
    output logic             wrap
);

    localparam int TOTAL = total_len(ACTIVE_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(ACTIVE_LEN - 1);
    localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(ACTIVE_LEN + FRONT_LEN - 1);
    localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);

    axis_state_t state;

    always_comb begin
        state_next = state;
        wrap       = advance && (count == LAST);
        if (advance) begin
            if (count == END_ACTIVE)
                state_next = FRONT;
            else if (count == END_FRONT)
                state_next = SYNC;
            else if (count == END_SYNC)
                state_next = BACK;
            else if (count == LAST)
                state_next = ACTIVE;
        end
    end

    // Reset parks the axis on its last position so the first advance lands on 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= LAST;
            state <= BACK;
        end else if (advance) begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
            state <= state_next;
        end
    end

endmodule

// File: rtl/pixel_timing_gen.sv
// Raster timing generator: turns the divider's toggling pixel flag into x/y position,
// sync, active-video and line/frame start strobes.
module pixel_timing_gen
    import pixel_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic             flag_pixel,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    logic        flag_q;
    logic        pix_tick;
    logic        advance;
    logic        h_wrap;
    logic        v_wrap;
    axis_state_t h_next;
    axis_state_t v_next;

    // flag_q tracks even while disabled so re-enabling never replays an old edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            flag_q <= 1'b0;
        else
            flag_q <= flag_pixel;
    end

    assign pix_tick = flag_pixel & ~flag_q;
    assign advance  = pix_tick & enable;

    timing_axis #(
        .ACTIVE_LEN(H_ACTIVE),
        .FRONT_LEN (H_FRONT),
        .SYNC_LEN  (H_SYNC),
        .BACK_LEN  (H_BACK),
        .CNT_W     (CNT_W)
    ) u_h_axis (
        .clk       (clk),
        .n_rst     (n_rst),
        .advance   (advance),
        .count     (x),
        .state_next(h_next),
        .wrap      (h_wrap)
    );

    timing_axis #(
        .ACTIVE_LEN(V_ACTIVE),
        .FRONT_LEN (V_FRONT),
        .SYNC_LEN  (V_SYNC),
        .BACK_LEN  (V_BACK),
        .CNT_W     (CNT_W)
    ) u_v_axis (
        .clk       (clk),
        .n_rst     (n_rst),
        .advance   (h_wrap),
        .count     (y),
        .state_next(v_next),
        .wrap      (v_wrap)
    );

    // Strobes last one clk; level outputs follow the phases taken on this edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            active      <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (advance) begin
                active <= (h_next == ACTIVE) && (v_next == ACTIVE);
                hsync  <= (h_next == SYNC) ? SYNC_POL : ~SYNC_POL;
                vsync  <= (v_next == SYNC) ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Scoreboard bench for pixel_timing_gen with a tiny 8x6 raster (H 4/1/2/1, V 3/1/1/1).
module tb_pixel_timing_gen;

    localparam int HT = 8;
    localparam int VT = 6;

    logic       clk;
    logic       n_rst;
    logic       enable;
    logic       flag_pixel;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       ls;
        logic       fs;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int checks = 0;
    int errors = 0;

    int   m_x = HT - 1;
    int   m_y = VT - 1;
    logic m_flag = 1'b0;
    logic m_ls = 1'b0;
    logic m_fs = 1'b0;
    logic fp_level = 1'b0;
    string phase = "reset";

    pixel_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b0), .CNT_W(10)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (enable),
        .flag_pixel (flag_pixel),
        .x          (x),
        .y          (y),
        .active     (active),
        .hsync      (hsync),
        .vsync      (vsync),
        .line_start (line_start),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs are decoded from position ranges, independent of the DUT's phase machine.
    function automatic exp_t modelOut(input int px, input int py, input logic ls, input logic fs);
        exp_t e;
        e.x      = 10'(px);
        e.y      = 10'(py);
        e.active = (px < 4) && (py < 3);
        e.hsync  = (px == 5 || px == 6) ? 1'b0 : 1'b1;
        e.vsync  = (py == 4) ? 1'b0 : 1'b1;
        e.ls     = ls;
        e.fs     = fs;
        return e;
    endfunction

    task automatic checkOutput(input string name, input exp_t e);
        exp_t got;
        got = {x, y, active, hsync, vsync, line_start, frame_start};
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b",
                     name, $time, got.x, got.y, got.active, got.hsync, got.vsync, got.ls, got.fs,
                     e.x, e.y, e.active, e.hsync, e.vsync, e.ls, e.fs);
        end
    endtask

    // One clk of stimulus; the model predicts what the DUT shows after the next rising edge.
    task automatic applyStimulus(input logic fp, input logic en, input logic rst_n);
        logic tick;
        @(negedge clk);
        flag_pixel = fp;
        enable     = en;
        n_rst      = rst_n;
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (!rst_n) begin
            m_flag = 1'b0;
            m_x    = HT - 1;
            m_y    = VT - 1;
        end else begin
            tick   = fp & ~m_flag & en;
            m_flag = fp;
            if (tick) begin
                if (m_x == HT - 1) begin
                    m_x  = 0;
                    m_ls = 1'b1;
                    if (m_y == VT - 1) begin
                        m_y  = 0;
                        m_fs = 1'b1;
                    end else begin
                        m_y = m_y + 1;
                    end
                end else begin
                    m_x = m_x + 1;
                end
            end
        end
        exp_q.push_back(modelOut(m_x, m_y, m_ls, m_fs));
        tag_q.push_back(phase);
    endtask

    task automatic holdCycles(input logic fp, input logic en, input int n);
        fp_level = fp;
        for (int i = 0; i < n; i++)
            applyStimulus(fp, en, 1'b1);
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) begin
            holdCycles(1'b1, 1'b1, 4);
            holdCycles(1'b0, 1'b1, 4);
        end
    endtask

    // Monitor: the DUT presents a fresh output every clk, compared just after the edge.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checkOutput(t, e);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int drain;
        n_rst      = 1'b0;
        enable     = 1'b0;
        flag_pixel = 1'b0;

        phase = "reset";
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        phase = "release";
        applyStimulus(1'b0, 1'b1, 1'b1);

        phase = "full_frame";
        tickN(HT * VT);

        phase = "to_x2";
        tickN(3);

        phase = "enable_low";
        holdCycles(1'b1, 1'b0, 4);
        holdCycles(1'b0, 1'b0, 4);
        holdCycles(1'b1, 1'b0, 4);
        phase = "reenable_high";
        holdCycles(1'b1, 1'b1, 4);
        holdCycles(1'b0, 1'b1, 4);
        phase = "step_x3";
        holdCycles(1'b1, 1'b1, 4);
        holdCycles(1'b0, 1'b1, 4);

        phase = "to_x5_y4";
        tickN(34);

        phase = "async_reset";
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        m_flag = 1'b0;
        m_x = HT - 1;
        m_y = VT - 1;
        #1;
        checkOutput("async_reset_immediate", modelOut(HT - 1, VT - 1, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        phase = "post_reset_first";
        applyStimulus(1'b0, 1'b1, 1'b1);
        tickN(1);

        phase = "flag_held_high";
        holdCycles(1'b1, 1'b1, 20);
        phase = "flag_falling";
        holdCycles(1'b0, 1'b1, 8);

        phase = "tail";
        tickN(10);

        drain = 0;
        while (exp_q.size() > 0 && drain < 8) begin
            @(posedge clk);
            drain++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
